// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller: FSM state encoding,
// default register/OAM addresses and the echo-RAM page remap helper.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'hFF46;
  localparam logic [15:0] OAM_LO           = 16'hFE00;
  localparam logic [7:0]  ECHO_PAGE_MIN    = 8'hE0;
  localparam logic [7:0]  ECHO_PAGE_OFS    = 8'h20;

  function automatic logic is_echo_page(input logic [7:0] page);
    return page >= ECHO_PAGE_MIN;
  endfunction

  // Pages E0..FF mirror C0..DF, so the source is taken from the work RAM copy.
  function automatic logic [7:0] echo_remap(input logic [7:0] page);
    return is_echo_page(page) ? (page - ECHO_PAGE_OFS) : page;
  endfunction

endpackage

// File: rtl/oam_dma_reg.sv
// DMA page register: address decode, write-strobe edge detect, page latch,
// echo-RAM source remap with a one-cycle wrap pulse, and combinational readback.
module oam_dma_reg
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_l,
  input  logic [15:0] i_reg_addr,
  input  logic [7:0]  i_reg_data,
  input  logic        i_reg_we_l,
  input  logic        i_reg_re_l,
  input  logic        i_load,
  output logic        o_trigger,
  output logic [7:0]  o_reg_data,
  output logic        o_reg_data_en,
  output logic [7:0]  o_src_page,
  output logic        o_src_wrap
);

  logic       w_addr_hit;
  logic       w_we_hit;
  logic       r_we_hit_prev;
  logic [7:0] r_page;
  logic       r_src_wrap;

  assign w_addr_hit = (i_reg_addr == DMA_REG_ADDR);
  assign w_we_hit   = w_addr_hit & ~i_reg_we_l;
  // A strobe held across several cycles only triggers on its first cycle.
  assign o_trigger  = w_we_hit & ~r_we_hit_prev;

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_we_hit_prev <= 1'b0;
      r_page        <= 8'h00;
      r_src_wrap    <= 1'b0;
    end else begin
      r_we_hit_prev <= w_we_hit;
      r_src_wrap    <= i_load & is_echo_page(i_reg_data);
      if (i_load) begin
        r_page <= i_reg_data;
      end
    end
  end

  assign o_reg_data_en = w_addr_hit & ~i_reg_re_l;
  assign o_reg_data    = o_reg_data_en ? r_page : 8'h00;
  assign o_src_page    = echo_remap(r_page);
  assign o_src_wrap    = r_src_wrap;

endmodule

// File: rtl/oam_dma_controller.sv
// GBC OAM DMA sequencer: copies XFER_LEN bytes from {page,00} to OAM through the
// router DMA ports. Define OAM_DMA_RESTART_EN to let a trigger restart an active transfer.
module oam_dma_controller
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_BASE     = OAM_LO,
  parameter int          XFER_LEN     = 160,
  parameter int          START_DELAY  = 1
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_REG_ADDR,
  input  logic [7:0]  I_REG_DATA,
  input  logic        I_REG_WE_L,
  input  logic        I_REG_RE_L,
  output logic [7:0]  O_REG_DATA,
  output logic        O_REG_DATA_EN,
  output logic [15:0] O_RDMA_ADDR,
  output logic        O_RDMA_RE_L,
  input  logic [7:0]  I_RDMA_DATA,
  output logic [15:0] O_WDMA_ADDR,
  output logic [7:0]  O_WDMA_DATA,
  output logic        O_WDMA_WE_L,
  output logic        O_DMA_ACTIVE,
  output logic        O_SRC_WRAP
);

`ifdef OAM_DMA_RESTART_EN
  localparam logic RESTART_EN = 1'b1;
`else
  localparam logic RESTART_EN = 1'b0;
`endif

  localparam logic [7:0] LAST_IDX   = 8'(XFER_LEN - 1);
  localparam logic [2:0] DELAY_INIT = 3'(START_DELAY - 1);

  dma_state_e  r_state;
  logic [7:0]  r_idx;
  logic [2:0]  r_dly_cnt;
  logic [15:0] r_rdma_addr;
  logic        r_rdma_re_l;
  logic [15:0] r_wdma_addr;
  logic        r_wdma_we_l;
  logic        r_active;

  logic        w_trigger;
  logic        w_load;
  logic [7:0]  w_src_page;
  logic [7:0]  w_start_page;
  logic [7:0]  w_idx_inc;

  oam_dma_reg #(
    .DMA_REG_ADDR (DMA_REG_ADDR)
  ) u_reg (
    .i_clk         (I_CLK),
    .i_reset_l     (I_RESET_L),
    .i_reg_addr    (I_REG_ADDR),
    .i_reg_data    (I_REG_DATA),
    .i_reg_we_l    (I_REG_WE_L),
    .i_reg_re_l    (I_REG_RE_L),
    .i_load        (w_load),
    .o_trigger     (w_trigger),
    .o_reg_data    (O_REG_DATA),
    .o_reg_data_en (O_REG_DATA_EN),
    .o_src_page    (w_src_page),
    .o_src_wrap    (O_SRC_WRAP)
  );

  // A trigger during a transfer (including its final WRITE) only counts when restart is enabled.
  assign w_load       = w_trigger & ((r_state == ST_IDLE) | RESTART_EN);
  // With no start delay the first READ issues before the page register has been updated.
  assign w_start_page = w_load ? echo_remap(I_REG_DATA) : w_src_page;
  assign w_idx_inc    = r_idx + 8'd1;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_state     <= ST_IDLE;
      r_idx       <= 8'h00;
      r_dly_cnt   <= 3'd0;
      r_rdma_addr <= 16'h0000;
      r_rdma_re_l <= 1'b1;
      r_wdma_addr <= 16'h0000;
      r_wdma_we_l <= 1'b1;
      r_active    <= 1'b0;
    end else begin
      r_rdma_re_l <= 1'b1;
      r_wdma_we_l <= 1'b1;
      if (w_load) begin
        r_idx    <= 8'h00;
        r_active <= 1'b1;
        if (START_DELAY == 0) begin
          r_state     <= ST_READ;
          r_rdma_re_l <= 1'b0;
          r_rdma_addr <= {w_start_page, 8'h00};
        end else begin
          r_state   <= ST_DELAY;
          r_dly_cnt <= DELAY_INIT;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_active <= 1'b0;
          end
          ST_DELAY: begin
            if (r_dly_cnt == 3'd0) begin
              r_state     <= ST_READ;
              r_rdma_re_l <= 1'b0;
              r_rdma_addr <= {w_src_page, r_idx};
            end else begin
              r_dly_cnt <= r_dly_cnt - 3'd1;
            end
          end
          ST_READ: begin
            r_state     <= ST_WRITE;
            r_wdma_we_l <= 1'b0;
            r_wdma_addr <= OAM_BASE + {8'h00, r_idx};
          end
          ST_WRITE: begin
            r_idx <= w_idx_inc;
            if (r_idx == LAST_IDX) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end else begin
              r_state     <= ST_READ;
              r_rdma_re_l <= 1'b0;
              r_rdma_addr <= {w_src_page, w_idx_inc};
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_RDMA_ADDR  = r_rdma_addr;
  assign O_RDMA_RE_L  = r_rdma_re_l;
  assign O_WDMA_ADDR  = r_wdma_addr;
  assign O_WDMA_WE_L  = r_wdma_we_l;
  // Read data arrives the cycle after the READ strobe, which is exactly the WRITE cycle.
  assign O_WDMA_DATA  = r_wdma_we_l ? 8'h00 : I_RDMA_DATA;
  assign O_DMA_ACTIVE = r_active;

endmodule
